// File: rtl/cu_bubble_stage_if.sv
// Bundle between the control unit and cu_bubble_stage.
// master: control-unit / fetch side; slave: the bubble stage itself.
interface cu_bubble_stage_if #(
  parameter int unsigned CTRL_W  = 9,
  parameter int unsigned STALL_W = 2
) ();

  logic [CTRL_W-1:0]  ctrl_in;
  logic               valid_in;
  logic               gate_in;
  logic               stall_req;
  logic [STALL_W-1:0] stall_len;
  logic               flush;
  logic [CTRL_W-1:0]  ctrl_out;
  logic               valid_out;
  logic               hold;
  logic               stall_busy;
  logic [15:0]        bubble_count;

  modport master (
    output ctrl_in, valid_in, gate_in, stall_req, stall_len, flush,
    input  ctrl_out, valid_out, hold, stall_busy, bubble_count
  );

  modport slave (
    input  ctrl_in, valid_in, gate_in, stall_req, stall_len, flush,
    output ctrl_out, valid_out, hold, stall_busy, bubble_count
  );

endinterface

// File: rtl/cu_bubble_stage.sv
// Registered pass/bubble stage between the control unit and ID/EX.
// Passes the control bundle through, or substitutes NOP_VALUE on gate-off,
// flush, or a multi-cycle stall request; hold tells fetch/decode to freeze.
// Optional macro CU_BUBBLE_STATS_EN enables the saturating bubble counter;
// without it bubble_count is tied to zero.
// CTRL_W/STALL_W must match the parameters of the connected interface.
module cu_bubble_stage #(
  parameter int unsigned       CTRL_W    = 9,
  parameter int unsigned       STALL_W   = 2,
  parameter logic [CTRL_W-1:0] NOP_VALUE = '0
) (
  input logic              clk,
  input logic              reset,
  cu_bubble_stage_if.slave bus
);

  // One-hot so a corrupted encoding is detectable and falls into default.
  typedef enum logic [1:0] {
    StRun   = 2'b01,
    StStall = 2'b10
  } state_e;

  state_e             state_q;
  logic [STALL_W-1:0] cnt_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               valid_q;
  logic               busy_q;

  logic stall_start;
  logic pass_now;

  // A request with length zero is the same as no request.
  assign stall_start = bus.stall_req && (bus.stall_len != '0);

  // High exactly on edges that load a real instruction into ctrl_out.
  assign pass_now = (state_q == StRun) && !bus.flush && !stall_start &&
                    bus.valid_in && bus.gate_in;

  assign bus.hold = !reset && !bus.flush &&
                    ((state_q == StStall) || ((state_q == StRun) && stall_start));

  assign bus.ctrl_out   = ctrl_q;
  assign bus.valid_out  = valid_q;
  assign bus.stall_busy = busy_q;

  // FSM with registered outputs; every path defaults to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ctrl_q  <= NOP_VALUE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ctrl_q  <= NOP_VALUE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      case (state_q)
        StRun: begin
          if (bus.flush) begin
            state_q <= StRun;
          end else if (stall_start) begin
            // This edge is the first bubble; cnt counts the ones still owed.
            cnt_q <= bus.stall_len - STALL_W'(1);
            if (bus.stall_len > STALL_W'(1)) begin
              state_q <= StStall;
              busy_q  <= 1'b1;
            end
          end else if (bus.valid_in && bus.gate_in) begin
            ctrl_q  <= bus.ctrl_in;
            valid_q <= 1'b1;
          end
        end
        StStall: begin
          if (bus.flush || (cnt_q <= STALL_W'(1))) begin
            // Last owed bubble, aborted stall, or the unreachable cnt==0.
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            cnt_q  <= cnt_q - STALL_W'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef CU_BUBBLE_STATS_EN
  logic [15:0] bubble_count_q;

  // Count every non-reset edge that loads valid_out with 0, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_q <= 16'h0000;
    end else if (!pass_now && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_q <= bubble_count_q + 16'h0001;
    end
  end

  assign bus.bubble_count = bubble_count_q;
`else
  assign bus.bubble_count = 16'h0000;
`endif

endmodule
